// File: rtl/uart_cmd_wrapper.sv
// Bridges UART bytes to 16-bit commands (high byte first) and pushes
// 8-bit response bytes back out through the UART transmitter.
module uart_cmd_wrapper #(
  parameter int unsigned TO_W    = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_ovr
);

  typedef enum logic [1:0] {RX_H, RX_L, RX_VAL} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  rx_state_t       rx_state;
  tx_state_t       tx_state;
  logic [TO_W-1:0] to_cnt;

  // Bytes are left with the UART core while a command is pending.
  always_comb begin
    clr_rx_rdy = 1'b0;
    if (rx_state == RX_H || rx_state == RX_L)
      clr_rx_rdy = rx_rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_H;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      case (rx_state)
        RX_H: begin
          if (rx_rdy) begin
            cmd[15:8] <= rx_data;
            to_cnt    <= '0;
            rx_state  <= RX_L;
          end
        end
        RX_L: begin
          if (rx_rdy) begin
            cmd[7:0] <= rx_data;
            cmd_rdy  <= 1'b1;
            rx_state <= RX_VAL;
          end else if (to_cnt == TO_LAST) begin
            rx_state <= RX_H;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RX_VAL: begin
          if (clr_cmd_rdy) begin
            cmd_rdy  <= 1'b0;
            rx_state <= RX_H;
          end
        end
        default: rx_state <= RX_H;
      endcase
    end
  end

  // A request coinciding with tx_done chains straight into the next byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_data   <= '0;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      tx_ovr    <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_data  <= resp;
            trmt     <= 1'b1;
            tx_state <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done) begin
            resp_sent <= 1'b1;
            if (send_resp) begin
              tx_data <= resp;
              trmt    <= 1'b1;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else if (send_resp) begin
            tx_ovr <= 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: directed scenarios plus a
// randomized phase compared each cycle against a behavioural model.
module tb_uart_cmd_wrapper;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_rx_rdy;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_ovr;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.TO_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .tx_data(tx_data), .trmt(trmt),
    .tx_done(tx_done), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_ovr(tx_ovr)
  );

  int errors = 0;
  int checks = 0;
  int n_clr = 0, n_trmt = 0, n_sent = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending high byte ages each idle cycle and is
  // dropped after TMO of them; responses are accepted whenever the
  // transmitter is free or frees up in the same cycle.
  logic [15:0]  m_cmd;
  logic         m_cmd_rdy, m_have_hi;
  int unsigned  m_age;
  logic [7:0]   m_tx_data;
  logic         m_trmt, m_resp_sent, m_ovr, m_busy;
  logic         consumed;
  logic         accept;

  assign accept = send_resp && (!m_busy || tx_done);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cmd <= '0; m_cmd_rdy <= 1'b0; m_have_hi <= 1'b0; m_age <= 0;
      m_tx_data <= '0; m_trmt <= 1'b0; m_resp_sent <= 1'b0;
      m_ovr <= 1'b0; m_busy <= 1'b0; consumed <= 1'b0;
    end else begin
      consumed <= rx_rdy && !m_cmd_rdy;
      if (m_cmd_rdy) begin
        if (clr_cmd_rdy) m_cmd_rdy <= 1'b0;
      end else if (rx_rdy) begin
        if (m_have_hi) begin
          m_cmd[7:0] <= rx_data;
          m_cmd_rdy  <= 1'b1;
          m_have_hi  <= 1'b0;
        end else begin
          m_cmd[15:8] <= rx_data;
          m_have_hi   <= 1'b1;
          m_age       <= 0;
        end
      end else if (m_have_hi) begin
        m_age <= m_age + 1;
        if (m_age + 1 == TMO) m_have_hi <= 1'b0;
      end
      m_resp_sent <= m_busy && tx_done;
      m_trmt      <= accept;
      if (accept) m_tx_data <= resp;
      if (m_busy && !tx_done && send_resp) m_ovr <= 1'b1;
      m_busy <= accept || (m_busy && !tx_done);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmd", cmd, m_cmd);
      chk("cmd_rdy", cmd_rdy, m_cmd_rdy);
      chk("clr_rx_rdy", clr_rx_rdy, rx_rdy && !m_cmd_rdy);
      chk("tx_data", tx_data, m_tx_data);
      chk("trmt", trmt, m_trmt);
      chk("resp_sent", resp_sent, m_resp_sent);
      chk("tx_ovr", tx_ovr, m_ovr);
      if (clr_rx_rdy) n_clr++;
      if (trmt) n_trmt++;
      if (resp_sent) n_sent++;
    end
  end

  // Advance one clock; the UART core drops rx_rdy once its byte is taken.
  task automatic tick();
    @(posedge clk);
    #1;
    if (consumed) rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    tx_done     = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 40 && rx_rdy; i++) tick();
    chk("rx_consumed", rx_rdy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd"}, cmd, 16'h0);
    chk({tag, "_cmd_rdy"}, cmd_rdy, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h0);
    chk({tag, "_trmt"}, trmt, 1'b0);
    chk({tag, "_resp_sent"}, resp_sent, 1'b0);
    chk({tag, "_tx_ovr"}, tx_ovr, 1'b0);
    chk({tag, "_clr_rx_rdy"}, clr_rx_rdy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rx_div;

    @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Command assembly
    n_clr = 0;
    put_byte(8'h47);
    put_byte(8'h12);
    chk("asm_cmd", cmd, 16'h4712);
    chk("asm_cmd_rdy", cmd_rdy, 1'b1);
    chk("asm_clr_count", n_clr, 2);

    // Back-pressure while a command is pending, then release
    rx_data = 8'hC0;
    rx_rdy  = 1'b1;
    repeat (3) tick();
    chk("bp_held", rx_rdy, 1'b1);
    chk("bp_clr_count", n_clr, 2);
    clr_cmd_rdy = 1'b1;
    tick();
    chk("rel_cmd_rdy", cmd_rdy, 1'b0);
    chk("rel_not_yet", rx_rdy, 1'b1);
    tick();
    chk("rel_consumed", rx_rdy, 1'b0);
    chk("rel_hi", cmd[15:8], 8'hC0);
    chk("rel_clr_count", n_clr, 3);
    put_byte(8'h3C);
    chk("rel_cmd", cmd, 16'hC03C);
    clr_cmd_rdy = 1'b1;
    tick();

    // Timeout: TMO idle cycles discard the high byte
    put_byte(8'h11);
    repeat (TMO) tick();
    put_byte(8'h22);
    put_byte(8'h33);
    chk("to_cmd", cmd, 16'h2233);
    clr_cmd_rdy = 1'b1;
    tick();
    // Last cycle before the timeout still accepts the low byte
    put_byte(8'h44);
    repeat (TMO - 1) tick();
    put_byte(8'h55);
    chk("to_edge_cmd", cmd, 16'h4455);
    clr_cmd_rdy = 1'b1;
    tick();

    // Single response
    resp = 8'hA5;
    send_resp = 1'b1;
    tick();
    chk("resp_trmt", trmt, 1'b1);
    chk("resp_tx_data", tx_data, 8'hA5);
    repeat (19) tick();
    tx_done = 1'b1;
    tick();
    chk("resp_sent_hi", resp_sent, 1'b1);
    tick();
    chk("resp_sent_lo", resp_sent, 1'b0);

    // Streaming dump of four bytes
    n_trmt = 0;
    n_sent = 0;
    resp = 8'hB0;
    send_resp = 1'b1;
    tick();
    for (int k = 1; k < 4; k++) begin
      repeat (5) tick();
      tx_done   = 1'b1;
      send_resp = 1'b1;
      resp      = 8'(8'hB0 + k);
      tick();
      chk("stream_tx_data", tx_data, 8'(8'hB0 + k));
    end
    repeat (5) tick();
    tx_done = 1'b1;
    tick();
    tick();
    chk("stream_trmt_count", n_trmt, 4);
    chk("stream_sent_count", n_sent, 4);
    chk("stream_ovr", tx_ovr, 1'b0);
    resp = 8'h10;
    send_resp = 1'b1;
    tick();
    repeat (3) tick();
    resp = 8'h99;
    send_resp = 1'b1;
    tick();
    chk("ovr_flag", tx_ovr, 1'b1);
    chk("ovr_tx_data", tx_data, 8'h10);
    tx_done = 1'b1;
    tick();
    tick();

    // Asynchronous reset mid-command and mid-transmission
    put_byte(8'h77);
    resp = 8'h5A;
    send_resp = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    tx_done = 1'b1;
    tick();
    chk("post_rst_no_sent", resp_sent, 1'b0);
    put_byte(8'h01);
    put_byte(8'h02);
    chk("post_rst_cmd", cmd, 16'h0102);
    chk("post_rst_cmd_rdy", cmd_rdy, 1'b1);

    // Randomized traffic; rx rate alternates to exercise timeouts
    rx_div = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) rx_div = (rx_div == 2) ? 15 : 2;
      if ($urandom_range(999) == 0) begin
        rx_rdy = 1'b0;
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        tick();
        continue;
      end
      if (!rx_rdy && $urandom_range(rx_div - 1) == 0) begin
        rx_data = 8'($urandom);
        rx_rdy  = 1'b1;
      end
      clr_cmd_rdy = ($urandom_range(5) == 0);
      send_resp   = ($urandom_range(6) == 0);
      resp        = 8'($urandom);
      tx_done     = ($urandom_range(7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_wrapper.md
# uart_cmd_wrapper

Byte-to-command bridge between the UART core and the command/configuration block. It assembles two received UART bytes (high byte first) into the 16-bit `cmd` word and presents it with `cmd_rdy` until the command block releases it. In the other direction it launches each 8-bit `resp` byte from the command block onto the UART transmitter and reports completion with `resp_sent`. Receive and transmit paths are independent, so multi-byte dump responses can stream while `cmd_rdy` stays high.

## Interface

Parameters:
- `TO_W`, default 16: width of the inter-byte timeout counter.
- `TIMEOUT`, default 16'hFFFF: clocks allowed between the high and low command bytes. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock domain; `rst` is asynchronous and active-high.
- `rx_rdy`  in  1  UART core holds a received byte.
- `rx_data`  in  8  received byte; valid while `rx_rdy` is high.
- `clr_rx_rdy`  out  1  combinational pulse; consumes the byte, and the core drops `rx_rdy` next cycle.
- `tx_data`  out  8  byte to transmit.
- `trmt`  out  1  registered one-cycle pulse; starts UART transmission.
- `tx_done`  in  1  one-cycle pulse; UART finished transmitting.
- `cmd`  out  16  assembled command word.
- `cmd_rdy`  out  1  `cmd` valid; held until cleared.
- `clr_cmd_rdy`  in  1  command block has finished with `cmd`.
- `resp`  in  8  response byte; sampled when `send_resp` is high.
- `send_resp`  in  1  one-cycle request to transmit `resp`.
- `resp_sent`  out  1  registered one-cycle pulse; response byte fully transmitted.
- `tx_ovr`  out  1  sticky flag: a response request was dropped.

## Operation

Receive FSM has three states: RX_H, RX_L and RX_VAL.

- **RX_H**
  - When `rx_rdy` is high: `clr_rx_rdy` = 1, `cmd[15:8]` ← `rx_data`, clear the timeout counter, go to RX_L.
- **RX_L**
  - When `rx_rdy` is high: `clr_rx_rdy` = 1, `cmd[7:0]` ← `rx_data`, `cmd_rdy` ← 1, go to RX_VAL.
  - Otherwise the counter increments each cycle. When the counter reaches `TIMEOUT`-1: discard the high byte, go to RX_H. `cmd` and `cmd_rdy` are unchanged.
- **RX_VAL**
  - `cmd` is frozen.
  - Incoming bytes are not consumed: `clr_rx_rdy` = 0, which back-pressures the UART core.
  - When `clr_cmd_rdy` is high: `cmd_rdy` ← 0, go to RX_H.
- `clr_cmd_rdy` outside RX_VAL is ignored.
- A `clr_cmd_rdy` cycle with `rx_rdy` high does not consume the byte. The byte is consumed the following cycle, in RX_H.

Transmit FSM has two states: TX_IDLE and TX_BUSY.

- **TX_IDLE**
  - When `send_resp` is high: `tx_data` ← `resp`, `trmt` = 1 next cycle, go to TX_BUSY.
- **TX_BUSY**
  - When `tx_done` is high: `resp_sent` = 1 next cycle, go to TX_IDLE.
  - If `send_resp` arrives in the same cycle as `tx_done`, it is accepted: the new byte is latched, `trmt` pulses next cycle alongside `resp_sent`, and the FSM stays in TX_BUSY.
  - `send_resp` without `tx_done` is dropped, `tx_data` is unchanged, and `tx_ovr` ← 1.
- `tx_done` in TX_IDLE is ignored.

Reset values:
- `cmd` = 0, `cmd_rdy` = 0, `tx_data` = 0.
- `trmt` = 0, `resp_sent` = 0, `tx_ovr` = 0.
- Both FSMs start in their idle states (RX_H, TX_IDLE); the timeout counter is 0.

Reset mid-operation: a partially received command is discarded and any in-flight transmission is abandoned. No `resp_sent` is generated for it.

## Timing

- High byte accepted in cycle N (`rx_rdy` high in RX_H) → low byte can be accepted no earlier than cycle N+1.
- Low byte accepted in cycle M → `cmd_rdy` is high from cycle M+1.
- `clr_cmd_rdy` in cycle K → `cmd_rdy` is low from cycle K+1, and the next high byte can be accepted from cycle K+1.
- `send_resp` in cycle S → `trmt` high in cycle S+1, with `tx_data` already valid.
- `tx_done` in cycle D → `resp_sent` high in cycle D+1.
- Timeout: with no low byte, RX_L is left after exactly `TIMEOUT` cycles in the state.

## Test plan

- **Command assembly:** feed bytes 0x47 then 0x12 with `rx_rdy` → `cmd` = 0x4712 and `cmd_rdy` high 1 cycle after the second byte. Two `clr_rx_rdy` pulses total.
- **Back-pressure and release:** hold `cmd_rdy`, present byte 0xC0 → no `clr_rx_rdy` while in RX_VAL. Pulse `clr_cmd_rdy` → `cmd_rdy` low next cycle, 0xC0 consumed the cycle after as the new high byte.
- **Timeout:** `TIMEOUT` = 8, send 0x11 then wait 8 cycles, then send 0x22 and 0x33 → `cmd` = 0x2233; the 0x11 byte is lost.
- **Response path:** `send_resp` with `resp` = 0xA5 → `trmt` next cycle with `tx_data` = 0xA5. `tx_done` after 20 cycles → one-cycle `resp_sent`.
- **Streaming dump:** 4 responses, each `send_resp` issued in the same cycle as the prior `tx_done` → 4 `trmt` pulses, 4 `resp_sent` pulses, `tx_ovr` = 0. Then issue `send_resp` mid-transmission → `tx_ovr` = 1, `tx_data` unchanged.
- **Async reset:** assert `rst` between the high and low bytes and during TX_BUSY → all outputs 0 immediately. After release, a fresh 0x0102 assembles correctly.
